// File: rtl/act_sram_packer_pkg.sv
// act_sram_packer_pkg
// Shared constants and types for the activation SRAM write packer and the
// read-side logic that uses the same (ch, row, col) -> (addr, lane) layout.
// One SRAM word holds one 3x3 spatial block for all channels:
// 3 channels x 9 activations x 10 bits = 270 bits, split into 27 lanes.
package act_sram_packer_pkg;

  localparam int CH_NUM       = 3;
  localparam int ACT_PER_ADDR = 9;
  localparam int BW_PER_ACT   = 10;
  localparam int MAP_W_BLK    = 8;
  localparam int MAP_H_BLK    = 10;
  localparam int DEPTH        = 80;

  localparam int LANES  = CH_NUM * ACT_PER_ADDR;   // 27
  localparam int WORD_W = LANES * BW_PER_ACT;      // 270
  localparam int ADDR_W = 7;
  localparam int CH_W   = 2;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 5;
  localparam int LANE_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/act_sram_packer_if.sv
// act_stream_if / act_sram_wr_if
// act_stream_if  : valid/ready activation beat stream
//                  (in_valid, in_ready, in_ch, in_row, in_col, in_data, in_last).
//                  master = producer, slave = packer.
// act_sram_wr_if : masked SRAM write port
//                  (sram_csb, sram_wsb active-low; sram_wordmask 1 = keep lane).
//                  master = packer, slave = SRAM.
interface act_stream_if;
  import act_sram_packer_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [CH_W-1:0]       in_ch;
  logic [ROW_W-1:0]      in_row;
  logic [COL_W-1:0]      in_col;
  logic [BW_PER_ACT-1:0] in_data;
  logic                  in_last;

  modport master (output in_valid, in_ch, in_row, in_col, in_data, in_last,
                  input  in_ready);
  modport slave  (input  in_valid, in_ch, in_row, in_col, in_data, in_last,
                  output in_ready);
endinterface

interface act_sram_wr_if;
  import act_sram_packer_pkg::*;

  logic              sram_csb;
  logic              sram_wsb;
  logic [ADDR_W-1:0] sram_waddr;
  logic [WORD_W-1:0] sram_wdata;
  logic [LANES-1:0]  sram_wordmask;

  modport master (output sram_csb, sram_wsb, sram_waddr, sram_wdata, sram_wordmask);
  modport slave  (input  sram_csb, sram_wsb, sram_waddr, sram_wdata, sram_wordmask);
endinterface

// File: rtl/act_sram_packer_addr_map.sv
// act_addr_map
// Combinational mapping of an activation coordinate to its SRAM slot.
//   ch, row, col  : activation coordinate
//   addr          : SRAM word = (row/3)*MAP_W_BLK + col/3
//   lane          : ch*9 + (row%3)*3 + (col%3)
//   out_of_range  : coordinate lies outside the feature map / channel count
// Division by 3 is done with a ladder of constant compares so no divider is
// inferred; the remainder is the offset from the matched block base.
module act_addr_map
  import act_sram_packer_pkg::*;
(
  input  logic [CH_W-1:0]   ch,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic [LANE_W-1:0] lane,
  output logic              out_of_range
);

  logic [3:0]       blk_r;
  logic [3:0]       blk_c;
  logic [ROW_W-1:0] row_base;
  logic [COL_W-1:0] col_base;
  logic [1:0]       row_off;
  logic [1:0]       col_off;

  // Last threshold that the coordinate reaches selects the block index.
  always_comb begin
    blk_r    = '0;
    row_base = '0;
    for (int i = 0; i < MAP_H_BLK; i++) begin
      if (row >= ROW_W'(3 * i)) begin
        blk_r    = 4'(i);
        row_base = ROW_W'(3 * i);
      end
    end
    blk_c    = '0;
    col_base = '0;
    for (int j = 0; j < MAP_W_BLK; j++) begin
      if (col >= COL_W'(3 * j)) begin
        blk_c    = 4'(j);
        col_base = COL_W'(3 * j);
      end
    end
  end

  assign row_off = 2'(row - row_base);
  assign col_off = 2'(col - col_base);

  assign addr = ADDR_W'(blk_r * MAP_W_BLK + blk_c);
  assign lane = LANE_W'(ch * ACT_PER_ADDR + row_off * 3 + col_off);

  assign out_of_range = (ch  >= CH_W'(CH_NUM))
                     || (row >= ROW_W'(3 * MAP_H_BLK))
                     || (col >= COL_W'(3 * MAP_W_BLK));

endmodule

// File: rtl/act_sram_packer.sv
// act_sram_packer
// Gathers single-activation beats that land in the same SRAM word into a
// 27-lane pack buffer and writes each word once per fill with a lane mask.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_if      : activation beat stream (slave)
//   sram_if    : masked SRAM write port (master); registered outputs
//   done       : one-cycle pulse when the layer's final write is out
//   err        : sticky, set by any out-of-range beat, cleared by reset only
module act_sram_packer
  import act_sram_packer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  act_stream_if.slave   in_if,
  act_sram_wr_if.master sram_if,
  output logic          done,
  output logic          err
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] buf_addr, buf_addr_n;
  logic [WORD_W-1:0] buf_data, buf_data_n;
  logic [LANES-1:0]  lane_valid, lane_valid_n;
  logic              err_n, done_n;

  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic [WORD_W-1:0] flush_data;
  logic [LANES-1:0]  flush_mask;

  logic [ADDR_W-1:0] map_addr;
  logic [LANE_W-1:0] map_lane;
  logic              map_oor;
  logic              accept;
  logic [WORD_W-1:0] beat_data;
  logic [WORD_W-1:0] beat_field;
  logic [LANES-1:0]  beat_bit;
  logic [WORD_W-1:0] merged_data;
  logic [LANES-1:0]  merged_valid;

  act_addr_map u_map (
    .ch           (in_if.in_ch),
    .row          (in_if.in_row),
    .col          (in_if.in_col),
    .addr         (map_addr),
    .lane         (map_lane),
    .out_of_range (map_oor)
  );

  assign in_if.in_ready = (state != DRAIN);
  assign accept         = in_if.in_valid && in_if.in_ready;

  assign beat_data    = WORD_W'(in_if.in_data) << (map_lane * BW_PER_ACT);
  assign beat_field   = WORD_W'({BW_PER_ACT{1'b1}}) << (map_lane * BW_PER_ACT);
  assign beat_bit     = LANES'(1) << map_lane;
  assign merged_data  = (buf_data & ~beat_field) | beat_data;
  assign merged_valid = lane_valid | beat_bit;

  // Next-state logic. A flush always clears the buffer unless the same edge
  // reloads it with a beat for a different word.
  always_comb begin
    state_n      = state;
    buf_addr_n   = buf_addr;
    buf_data_n   = buf_data;
    lane_valid_n = lane_valid;
    err_n        = err;
    done_n       = 1'b0;
    flush        = 1'b0;
    flush_addr   = buf_addr;
    flush_data   = buf_data;
    flush_mask   = ~lane_valid;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (map_oor) begin
            err_n = 1'b1;
            if (in_if.in_last) state_n = DRAIN;
          end else if (in_if.in_last) begin
            flush        = 1'b1;
            flush_addr   = map_addr;
            flush_data   = beat_data;
            flush_mask   = ~beat_bit;
            buf_data_n   = '0;
            lane_valid_n = '0;
            state_n      = DRAIN;
          end else begin
            buf_addr_n   = map_addr;
            buf_data_n   = beat_data;
            lane_valid_n = beat_bit;
            state_n      = FILL;
          end
        end
      end

      FILL: begin
        if (accept) begin
          if (map_oor) begin
            err_n = 1'b1;
            if (in_if.in_last) begin
              flush        = 1'b1;
              buf_data_n   = '0;
              lane_valid_n = '0;
              state_n      = DRAIN;
            end
          end else if (map_addr == buf_addr) begin
            if (in_if.in_last || (&merged_valid)) begin
              flush        = 1'b1;
              flush_data   = merged_data;
              flush_mask   = ~merged_valid;
              buf_data_n   = '0;
              lane_valid_n = '0;
              state_n      = in_if.in_last ? DRAIN : IDLE;
            end else begin
              buf_data_n   = merged_data;
              lane_valid_n = merged_valid;
            end
          end else begin
            flush        = 1'b1;
            buf_addr_n   = map_addr;
            buf_data_n   = beat_data;
            lane_valid_n = beat_bit;
            if (in_if.in_last) state_n = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Single-cycle drain: any word still buffered goes out on the same
        // edge that raises done.
        if (lane_valid != '0) begin
          flush        = 1'b1;
          buf_data_n   = '0;
          lane_valid_n = '0;
        end
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State, buffer and registered SRAM port. Strobes idle high with the mask
  // all-ones so a stray strobe could never corrupt a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      buf_addr              <= '0;
      buf_data              <= '0;
      lane_valid            <= '0;
      err                   <= 1'b0;
      done                  <= 1'b0;
      sram_if.sram_csb      <= 1'b1;
      sram_if.sram_wsb      <= 1'b1;
      sram_if.sram_waddr    <= '0;
      sram_if.sram_wdata    <= '0;
      sram_if.sram_wordmask <= '1;
    end else begin
      state                 <= state_n;
      buf_addr              <= buf_addr_n;
      buf_data              <= buf_data_n;
      lane_valid            <= lane_valid_n;
      err                   <= err_n;
      done                  <= done_n;
      sram_if.sram_csb      <= ~flush;
      sram_if.sram_wsb      <= ~flush;
      sram_if.sram_wordmask <= flush ? flush_mask : '1;
      if (flush) begin
        sram_if.sram_waddr <= flush_addr;
        sram_if.sram_wdata <= flush_data;
      end
    end
  end

endmodule

// File: tb/tb_act_sram_packer.sv
// tb_act_sram_packer
// Directed bench for act_sram_packer. Each test pushes the SRAM writes it
// expects into a queue; a monitor pops and compares on every strobe.
module tb_act_sram_packer;
  import act_sram_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic done;
  logic err;

  always #5 clk = ~clk;

  act_stream_if  s_if ();
  act_sram_wr_if w_if ();

  act_sram_packer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_if   (s_if),
    .sram_if (w_if),
    .done    (done),
    .err     (err)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  mask;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic checkOutput(input string name, input logic [WORD_W-1:0] act,
                             input logic [WORD_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [WORD_W-1:0] putLane(input logic [WORD_W-1:0] d,
                                                input int lane,
                                                input logic [BW_PER_ACT-1:0] v);
    logic [WORD_W-1:0] r;
    r = d;
    r[lane*BW_PER_ACT +: BW_PER_ACT] = v;
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] keepBits(input logic [LANES-1:0] mask);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      if (!mask[k]) r[k*BW_PER_ACT +: BW_PER_ACT] = '1;
    return r;
  endfunction

  // Only written lanes are compared; kept lanes carry don't-care data.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && w_if.sram_csb === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0d mask %0h, required no write",
                 w_if.sram_waddr, w_if.sram_wordmask);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("wsb", WORD_W'(w_if.sram_wsb), WORD_W'(0));
        checkOutput("waddr", WORD_W'(w_if.sram_waddr), WORD_W'(e.addr));
        checkOutput("wordmask", WORD_W'(w_if.sram_wordmask), WORD_W'(e.mask));
        checkOutput("wdata", w_if.sram_wdata & keepBits(e.mask), e.data & keepBits(e.mask));
      end
    end
  end

  // Called just after a negedge; returns at the negedge after the accept edge.
  task automatic applyStimulus(input int ch, input int row, input int col,
                               input logic [BW_PER_ACT-1:0] data, input logic last);
    int waited = 0;
    while (s_if.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (s_if.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got in_ready %b, required 1", s_if.in_ready);
    end
    s_if.in_valid = 1'b1;
    s_if.in_ch    = CH_W'(ch);
    s_if.in_row   = ROW_W'(row);
    s_if.in_col   = COL_W'(col);
    s_if.in_data  = data;
    s_if.in_last  = last;
    @(posedge clk);
    @(negedge clk);
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
  endtask

  initial begin
    wr_t e;
    int  done_cnt;
    int  busy_cnt;

    rst_n         = 1'b0;
    s_if.in_valid = 1'b0;
    s_if.in_ch    = '0;
    s_if.in_row   = '0;
    s_if.in_col   = '0;
    s_if.in_data  = '0;
    s_if.in_last  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_csb", WORD_W'(w_if.sram_csb), WORD_W'(1));
    checkOutput("rst_wsb", WORD_W'(w_if.sram_wsb), WORD_W'(1));
    checkOutput("rst_wordmask", WORD_W'(w_if.sram_wordmask), WORD_W'(27'h7FFFFFF));
    checkOutput("rst_waddr", WORD_W'(w_if.sram_waddr), WORD_W'(0));
    checkOutput("rst_wdata", w_if.sram_wdata, WORD_W'(0));
    checkOutput("rst_in_ready", WORD_W'(s_if.in_ready), WORD_W'(1));
    checkOutput("rst_done", WORD_W'(done), WORD_W'(0));
    checkOutput("rst_err", WORD_W'(err), WORD_W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Full block (0,0): lane k carries k, one write with nothing kept
    e.addr = 7'd0; e.mask = '0; e.data = '0;
    for (int k = 0; k < LANES; k++) e.data = putLane(e.data, k, 10'(k));
    exp_q.push_back(e);
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          applyStimulus(ch, r, c, 10'(ch * 9 + r * 3 + c), 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("full_in_ready", WORD_W'(s_if.in_ready), WORD_W'(1));
    checkOutput("full_done", WORD_W'(done), WORD_W'(0));

    // Single beat ch0,row4,col7 -> addr 10, lane 4
    e.addr = 7'd10; e.mask = ~(27'd1 << 4); e.data = putLane('0, 4, 10'h155);
    exp_q.push_back(e);
    applyStimulus(0, 4, 7, 10'h155, 1'b1);
    checkOutput("single_done_early", WORD_W'(done), WORD_W'(0));
    checkOutput("single_ready_drain", WORD_W'(s_if.in_ready), WORD_W'(0));
    @(negedge clk);
    checkOutput("single_done_pulse", WORD_W'(done), WORD_W'(1));
    @(negedge clk);
    checkOutput("single_done_clear", WORD_W'(done), WORD_W'(0));

    // Address change with in_last on the second beat
    e.addr = 7'd0; e.mask = ~(27'd1 << 9); e.data = putLane('0, 9, 10'h0AA);
    exp_q.push_back(e);
    e.addr = 7'd1; e.mask = ~27'd1; e.data = putLane('0, 0, 10'h155);
    exp_q.push_back(e);
    applyStimulus(1, 0, 0, 10'h0AA, 1'b0);
    applyStimulus(0, 0, 3, 10'h155, 1'b1);
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_if.in_ready === 1'b0) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    checkOutput("chg_drain_cycles", WORD_W'(busy_cnt), WORD_W'(1));
    checkOutput("chg_done_pulses", WORD_W'(done_cnt), WORD_W'(1));

    // Duplicate lane: last value wins
    e.addr = 7'd0; e.mask = ~(27'd1 | (27'd1 << 26));
    e.data = putLane(putLane('0, 0, 10'h3FF), 26, 10'h0F0);
    exp_q.push_back(e);
    applyStimulus(0, 0, 0, 10'h001, 1'b0);
    applyStimulus(0, 0, 0, 10'h3FF, 1'b0);
    applyStimulus(2, 2, 2, 10'h0F0, 1'b1);
    repeat (3) @(negedge clk);

    // Out of range row, then normal beat still packs; err stays set
    applyStimulus(0, 30, 0, 10'h2AA, 1'b0);
    checkOutput("oor_err_set", WORD_W'(err), WORD_W'(1));
    e.addr = 7'd0; e.mask = ~27'd1; e.data = putLane('0, 0, 10'h123);
    exp_q.push_back(e);
    applyStimulus(0, 0, 0, 10'h123, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("oor_err_sticky", WORD_W'(err), WORD_W'(1));

    // Out of range channel carrying in_last: drain and done, no write
    applyStimulus(3, 0, 0, 10'h000, 1'b1);
    checkOutput("oorlast_ready", WORD_W'(s_if.in_ready), WORD_W'(0));
    @(negedge clk);
    checkOutput("oorlast_done", WORD_W'(done), WORD_W'(1));

    // Far corner: ch2,row29,col23 -> addr 79, lane 26
    e.addr = 7'd79; e.mask = ~(27'd1 << 26); e.data = putLane('0, 26, 10'h3C3);
    exp_q.push_back(e);
    applyStimulus(2, 29, 23, 10'h3C3, 1'b1);
    repeat (3) @(negedge clk);

    // Reset mid-layer drops the buffered beat and clears err
    applyStimulus(1, 5, 5, 10'h111, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_csb", WORD_W'(w_if.sram_csb), WORD_W'(1));
    checkOutput("midrst_err", WORD_W'(err), WORD_W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    e.addr = 7'd8; e.mask = ~27'd1; e.data = putLane('0, 0, 10'h077);
    exp_q.push_back(e);
    applyStimulus(0, 3, 0, 10'h077, 1'b1);
    repeat (4) @(negedge clk);

    checkOutput("writes_outstanding", WORD_W'(exp_q.size()), WORD_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
